// File: rtl/attendance_pkg.sv
// rtl/attendance_pkg.sv - shared FSM state type, reserved ID and default table contents
package attendance_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam int RESERVED_ID = 0;

    // Slot i holds employee ID i+1 after reset, so ID 0 is never a default entry.
    function automatic int default_id(input int slot);
        return slot + 1;
    endfunction

endpackage

// File: rtl/attendance_id_table.sv
// rtl/attendance_id_table.sv - employee ID registers with enroll write port and indexed read (writable only with ENROLL_EN)
module attendance_id_table
    import attendance_pkg::*;
#(
    parameter int ID_W    = 3,
    parameter int NUM_EMP = 3,
    parameter int IDX_W   = (NUM_EMP > 1) ? $clog2(NUM_EMP) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_slot_i,
    input  logic [ID_W-1:0]  wr_id_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [ID_W-1:0]  rd_id_o
);

`ifdef ENROLL_EN
    logic [ID_W-1:0] ids_q [NUM_EMP];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_EMP; i++) begin
                ids_q[i] <= ID_W'(default_id(i));
            end
        end else if (wr_en_i) begin
            ids_q[wr_slot_i] <= wr_id_i;
        end
    end

    assign rd_id_o = ids_q[rd_idx_i];
`else
    // Table is frozen at its reset contents; write port and clock are sunk.
    logic [ID_W-1:0] ids_c [NUM_EMP];
    logic            unused_wr;

    for (genvar g = 0; g < NUM_EMP; g++) begin : g_const
        assign ids_c[g] = ID_W'(default_id(g));
    end

    assign unused_wr = ^{clk_i, rst_i, wr_en_i, wr_slot_i, wr_id_i};
    assign rd_id_o   = ids_c[rd_idx_i];
`endif

endmodule

// File: rtl/attendance_tracker.sv
// rtl/attendance_tracker.sv - fingerprint attendance tracker: sequential ID search, per-day attended flags (ENROLL_EN enables enrollment)
module attendance_tracker
    import attendance_pkg::*;
#(
    parameter int ID_W    = 3,
    parameter int NUM_EMP = 3,
    parameter int CNT_W   = $clog2(NUM_EMP + 1),
    parameter int IDX_W   = (NUM_EMP > 1) ? $clog2(NUM_EMP) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scan_valid,
    input  logic [ID_W-1:0]  scan_id,
    output logic             scan_ready,
    input  logic             on_time,
    input  logic             day_clear,
    input  logic             enroll_valid,
    input  logic [IDX_W-1:0] enroll_slot,
    input  logic [ID_W-1:0]  enroll_id,
    output logic             result_valid,
    output logic             accepted,
    output logic             already_attended,
    output logic [IDX_W-1:0] emp_idx,
    output logic [CNT_W-1:0] attend_count
);

`ifdef ENROLL_EN
    localparam bit ENROLL_ON = 1'b1;
`else
    localparam bit ENROLL_ON = 1'b0;
`endif

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_EMP - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(NUM_EMP);

    state_e             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [ID_W-1:0]    cap_id_q;
    logic               cap_on_time_q;
    logic [NUM_EMP-1:0] attended_q;
    logic [CNT_W-1:0]   count_q;
    logic               result_valid_q;
    logic               accepted_q;
    logic               already_q;
    logic [IDX_W-1:0]   emp_idx_q;

    logic [ID_W-1:0]    rd_id;
    logic               enroll_fire;
    logic               hit;
    logic               att_now;

    assign enroll_fire = ENROLL_ON && enroll_valid && (state_q == IDLE) && (enroll_slot <= LAST_IDX);
    assign hit         = (cap_id_q != ID_W'(RESERVED_ID)) && (rd_id == cap_id_q);
    // A clear landing on the deciding cycle makes the employee look unmarked.
    assign att_now     = attended_q[idx_q] && !day_clear;

    attendance_id_table #(
        .ID_W    (ID_W),
        .NUM_EMP (NUM_EMP),
        .IDX_W   (IDX_W)
    ) u_id_table (
        .clk_i     (clk),
        .rst_i     (rst),
        .wr_en_i   (enroll_fire),
        .wr_slot_i (enroll_slot),
        .wr_id_i   (enroll_id),
        .rd_idx_i  (idx_q),
        .rd_id_o   (rd_id)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            cap_id_q       <= '0;
            cap_on_time_q  <= 1'b0;
            attended_q     <= '0;
            count_q        <= '0;
            result_valid_q <= 1'b0;
            accepted_q     <= 1'b0;
            already_q      <= 1'b0;
            emp_idx_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (scan_valid) begin
                        cap_id_q      <= scan_id;
                        cap_on_time_q <= on_time;
                        idx_q         <= '0;
                        state_q       <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (hit || (idx_q == LAST_IDX)) begin
                        state_q        <= RESP;
                        result_valid_q <= 1'b1;
                        accepted_q     <= hit && !att_now && cap_on_time_q;
                        already_q      <= hit && att_now;
                        emp_idx_q      <= hit ? idx_q : '0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                RESP: begin
                    state_q        <= IDLE;
                    result_valid_q <= 1'b0;
                    accepted_q     <= 1'b0;
                    already_q      <= 1'b0;
                    emp_idx_q      <= '0;
                    if (accepted_q) begin
                        attended_q[emp_idx_q] <= 1'b1;
                        if (count_q < MAX_CNT) begin
                            count_q <= count_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Re-enrolling a slot forgets today's mark for it.
            if (enroll_fire && attended_q[enroll_slot]) begin
                attended_q[enroll_slot] <= 1'b0;
                if (count_q != '0) begin
                    count_q <= count_q - 1'b1;
                end
            end

            if (day_clear) begin
                attended_q <= '0;
                count_q    <= '0;
            end
        end
    end

    assign scan_ready       = (state_q == IDLE);
    assign result_valid     = result_valid_q;
    assign accepted         = accepted_q;
    assign already_attended = already_q;
    assign emp_idx          = emp_idx_q;
    assign attend_count     = count_q;

endmodule

// File: doc/attendance_tracker.md
# attendance_tracker

Parametrised fingerprint attendance tracker. It matches a scanned fingerprint ID against a table of NUM_EMP enrolled employee IDs and records one attendance per employee per day. It reports accepted, already-attended or rejected outcomes through a valid/ready handshake. It sits between the fingerprint reader front end and the attendance log / display logic.

## Interface
- ID_W, 3: fingerprint ID width; ID value 0 is reserved and never matches
- NUM_EMP, 3: number of employee slots; 1..2**ID_W-1
- CNT_W, $clog2(NUM_EMP+1): width of attend_count
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- scan_valid  in  1  scan request present
- scan_id  in  ID_W  fingerprint ID, held stable while scan_valid && !scan_ready
- scan_ready  out  1  block can accept a scan
- on_time  in  1  arrival window open; sampled on the scan accept cycle
- day_clear  in  1  one-cycle pulse; clears all attended flags and attend_count
- enroll_valid  in  1  write enroll_id into slot enroll_slot (ENROLL_EN only)
- enroll_slot  in  $clog2(NUM_EMP)  target slot
- enroll_id  in  ID_W  ID to store; 0 de-enrolls the slot
- result_valid  out  1  one-cycle result strobe
- accepted  out  1  first on-time scan of an enrolled employee today
- already_attended  out  1  enrolled employee already marked today
- emp_idx  out  $clog2(NUM_EMP)  matched slot; 0 when no match
- attend_count  out  CNT_W  employees marked today

## Operation
- Storage: per slot, ID register and attended flag.
- FSM states IDLE, SEARCH, RESP.
- IDLE: scan_ready=1. scan_valid=1 captures scan_id and on_time, clears idx, and moves to SEARCH.
- SEARCH: scan_ready=0. Compares slot[idx] with the captured ID, one slot per cycle.
  - On match, or when idx==NUM_EMP-1, moves to RESP with a match flag and slot index.
  - Otherwise idx increments.
- RESP: result_valid=1 for exactly one cycle, then returns to IDLE. Outcomes:
  - match && !attended && on_time: accepted=1. Sets attended[slot] and increments attend_count in the same cycle.
  - match && attended: already_attended=1, accepted=0, regardless of on_time.
  - match && !attended && !on_time: both flags 0.
  - no match, or captured ID 0: both flags 0, emp_idx=0.
- accepted, already_attended and emp_idx are valid only while result_valid=1. They are held 0 otherwise.
- attend_count saturates at NUM_EMP. It cannot exceed NUM_EMP by construction; the saturation check is still required.
- day_clear in any state clears flags and count on that edge.
  - If day_clear coincides with the RESP cycle, the clear wins. attended stays 0, count stays 0, and the result strobe is still issued with its computed flags.
- Enrollment is accepted only in IDLE. It is ignored in other states and does not stall the FSM.
  - An enroll write to a slot clears that slot's attended flag and decrements attend_count if the flag was set.
  - An enroll write coinciding with a scan accept in IDLE takes effect before the search starts.
- Duplicate IDs in the table: the lowest slot matches.

## Timing
- Reset values: state IDLE, scan_ready=1 (combinational from state), result_valid=0, accepted=0, already_attended=0, emp_idx=0, attend_count=0, all attended flags 0.
- Reset ID table: slot i = i+1, i.e. default IDs 1..NUM_EMP.
- Latency for a match in slot k: accept edge T, result_valid high in the cycle after edge T+k+1.
- Latency for no match: NUM_EMP+1 cycles after the accept edge.
- Throughput: one scan per (search length + 2) cycles.
- rst mid-search aborts the scan with no result strobe and restores the full reset state, including the ID table.

## Configuration
- ENROLL_EN defined: the enroll_* ports are live as described under Operation.
- ENROLL_EN undefined: the enroll_* ports remain present but are ignored. The ID table is constant at its reset values, and synthesis may reduce it to constants.

## Structure
- Shared package attendance_pkg:
  - state enum {IDLE, SEARCH, RESP}
  - function default_id(slot) returning slot+1
  - localparam RESERVED_ID = 0
- Sub-module attendance_id_table: ID registers, enroll write port and indexed read port. The FSM, attended flags and counter live in the top.

## Test plan
- Reset, then scan ID 2 with on_time=1 -> result_valid at accept+3, accepted=1, emp_idx=1, attend_count=1.
- Repeat scan ID 2 -> already_attended=1, accepted=0, count stays 1. Scan ID 5 (NUM_EMP=3) -> result at accept+4, all flags 0.
- Scan ID 1 with on_time=0 -> flags 0. Rescan ID 1 with on_time=1 -> accepted=1. Scan ID 0 -> rejected after full search.
- Mark all three employees, then a fourth scan of ID 3 -> count stays 3. day_clear pulse -> count 0, and rescan ID 3 is accepted.
- day_clear on the RESP cycle of an accepted scan -> strobe shows accepted=1, but count=0 and the flag stays cleared.
- ENROLL_EN defined: enroll slot 0 with ID 6, then scan ID 6 -> accepted at emp_idx=0; scan ID 1 -> rejected. rst mid-search -> no strobe, table back to IDs 1..3.
